// File: rtl/arb_sched_pkg.sv
// Shared types and constants for the KS10 backplane scheduler.
// Requester indices address the [0:2] vectors, so bit 0 is the CPU.
package arb_sched_pkg;

  localparam int WORD_W = 36;
  localparam int N_REQ  = 3;

  typedef logic [1:0]              idx_t;
  typedef logic [0:WORD_W-1]       word_t;
  typedef logic [0:N_REQ-1]        req_vec_t;
  typedef word_t [0:N_REQ-1]       word_vec_t;

  localparam idx_t REQ_CPU = 2'd0;
  localparam idx_t REQ_CSL = 2'd1;
  localparam idx_t REQ_UBA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic req_vec_t onehot(idx_t i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First requester found in the order a, b, c wins.
  function automatic req_vec_t pick_first(req_vec_t req, idx_t a, idx_t b, idx_t c);
    pick_first = '0;
    if (req[a])      pick_first[a] = 1'b1;
    else if (req[b]) pick_first[b] = 1'b1;
    else if (req[c]) pick_first[c] = 1'b1;
  endfunction

  function automatic word_t mux3(req_vec_t sel, word_vec_t w);
    return ({WORD_W{sel[REQ_CPU]}} & w[REQ_CPU]) |
           ({WORD_W{sel[REQ_CSL]}} & w[REQ_CSL]) |
           ({WORD_W{sel[REQ_UBA]}} & w[REQ_UBA]);
  endfunction

endpackage

// File: rtl/arb_sched_if.sv
// Bus bundle between the three masters, the memory port and the scheduler.
// master = requesters plus memory; slave = the scheduler itself.
interface arb_sched_if;
  import arb_sched_pkg::*;

  req_vec_t  req;
  word_vec_t req_addr;
  word_vec_t req_wdata;
  req_vec_t  ack;
  word_vec_t req_rdata;

  logic      mem_req;
  logic      mem_ack;
  word_t     mem_rdata;
  word_t     mem_wdata;
  word_t     addr;
  req_vec_t  gnt;
  logic      nxm;

  modport master (
    output req, req_addr, req_wdata, mem_ack, mem_rdata,
    input  ack, req_rdata, mem_req, mem_wdata, addr, gnt, nxm
  );

  modport slave (
    input  req, req_addr, req_wdata, mem_ack, mem_rdata,
    output ack, req_rdata, mem_req, mem_wdata, addr, gnt, nxm
  );

endinterface

// File: rtl/arb_sched_pick.sv
// Combinational winner selection: fixed UBA > CSL > CPU, or round-robin
// where the previous winner drops to lowest priority.
module arb_pick
  import arb_sched_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  req_vec_t req,
  input  req_vec_t last,
  output req_vec_t gnt
);

  always_comb begin
    gnt = '0;
    if (!RR)                gnt = pick_first(req, REQ_UBA, REQ_CSL, REQ_CPU);
    else if (last[REQ_CSL]) gnt = pick_first(req, REQ_UBA, REQ_CPU, REQ_CSL);
    else if (last[REQ_UBA]) gnt = pick_first(req, REQ_CPU, REQ_CSL, REQ_UBA);
    else                    gnt = pick_first(req, REQ_CSL, REQ_UBA, REQ_CPU);
  end

endmodule

// File: rtl/arb_sched.sv
// Three-master scheduler for the single KS10 memory port with NXM timeout.
//   state | meaning
//   IDLE  | waiting for any request; grant latches address/data
//   BUSY  | memREQ held, waiting for memACK or timeout
//   DONE  | dead cycle after ack pulse, requests ignored
module arb_sched
  import arb_sched_pkg::*;
#(
  parameter bit RR  = 1'b0,
  parameter int TMO = 64
) (
  input logic        clk,
  input logic        rst,
  arb_sched_if.slave bus
);

  localparam int CNT_W = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  if (TMO < 2) begin : g_bad_tmo
    $error("arb_sched: TMO=%0d is illegal, minimum is 2", TMO);
  end

  state_t           state_q, state_nx;
  req_vec_t         last_q, pick, gnt_q, ack_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout, grant_en, finish, to_nxm;
  logic             mem_req_q, nxm_q;
  word_t            addr_q, wdata_q, ret;
  word_vec_t        rdata_q;

  arb_pick #(.RR(RR)) u_pick (
    .req  (bus.req),
    .last (last_q),
    .gnt  (pick)
  );

  assign timeout = (cnt_q == CNT_LAST);
  // A late acknowledge beats the timeout, so data is taken whenever ack is up.
  assign ret     = bus.mem_ack ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:    if (|bus.req) state_nx = BUSY;
      BUSY:    if (bus.mem_ack || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_en = 1'b0;
    finish   = 1'b0;
    to_nxm   = 1'b0;
    unique case (state_q)
      IDLE: grant_en = |bus.req;
      BUSY: begin
        finish = bus.mem_ack | timeout;
        to_nxm = timeout & ~bus.mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q     <= '0;
      last_q    <= onehot(REQ_CPU);
      ack_q     <= '0;
      nxm_q     <= 1'b0;
      mem_req_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      ack_q <= '0;
      nxm_q <= 1'b0;
      if (grant_en) begin
        gnt_q     <= pick;
        last_q    <= pick;
        mem_req_q <= 1'b1;
        cnt_q     <= '0;
        addr_q    <= mux3(pick, bus.req_addr);
        wdata_q   <= mux3(pick, bus.req_wdata);
      end else if (finish) begin
        gnt_q     <= '0;
        ack_q     <= gnt_q;
        mem_req_q <= 1'b0;
        nxm_q     <= to_nxm;
        if (gnt_q[REQ_CPU]) rdata_q[REQ_CPU] <= ret;
        if (gnt_q[REQ_CSL]) rdata_q[REQ_CSL] <= ret;
        if (gnt_q[REQ_UBA]) rdata_q[REQ_UBA] <= ret;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.nxm       = nxm_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.addr      = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.req_rdata = rdata_q;

endmodule
